// File: rtl/tank_move_ctrl_if.sv
// tank_move_ctrl_if: command handshake (player input decoder -> controller)
// and collision probe (controller <-> map logic) grouped into one bundle.
// slave = controller side, master = requester / map side.
`timescale 1ns/1ps
interface tank_move_ctrl_if;
  logic       i_cmd_valid;
  logic [1:0] i_cmd_dir;
  logic       o_cmd_ready;
  logic       o_probe_valid;
  logic [5:0] o_probe_x;
  logic [5:0] o_probe_y;
  logic       i_probe_ack;
  logic       i_probe_hit;

  modport slave (
    input  i_cmd_valid, i_cmd_dir, i_probe_ack, i_probe_hit,
    output o_cmd_ready, o_probe_valid, o_probe_x, o_probe_y
  );

  modport master (
    output i_cmd_valid, i_cmd_dir, i_probe_ack, i_probe_hit,
    input  o_cmd_ready, o_probe_valid, o_probe_x, o_probe_y
  );
endinterface

// File: rtl/tank_move_ctrl.sv
// tank_move_ctrl: sequences one tank's grid position and heading.
// Accepts a direction command, optionally turns, probes the map for the
// target cell (skipped when the 5x5 footprint would leave the playfield),
// steps on a clear probe, then waits COOLDOWN_TICKS frame ticks.
// Optional feature macro: TANK_MOVE_TURN_IN_PLACE_EN -- when defined a
// direction change only rotates the tank; otherwise it rotates and steps.
`timescale 1ns/1ps
module tank_move_ctrl #(
  parameter int GAME_W         = 40,
  parameter int GAME_H         = 30,
  parameter int INIT_X         = 20,
  parameter int INIT_Y         = 15,
  parameter int INIT_DIR       = 0,
  parameter int COOLDOWN_TICKS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_tick,
  tank_move_ctrl_if.slave   bus,
  output logic [5:0]        o_tank_x,
  output logic [5:0]        o_tank_y,
  output logic [1:0]        o_tank_dir,
  output logic              o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_TURN, S_PROBE, S_MOVE, S_COOL} state_t;

  // Legal center range keeps the whole 5x5 footprint on the playfield.
  localparam logic signed [6:0] X_LO = 7'sd2;
  localparam logic signed [6:0] X_HI = 7'(GAME_W - 3);
  localparam logic signed [6:0] Y_LO = 7'sd2;
  localparam logic signed [6:0] Y_HI = 7'(GAME_H - 3);

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_cmd_dir;
  logic [7:0]            r_cnt;
  logic                  r_probe_valid;
  logic [5:0]            r_probe_x;
  logic [5:0]            r_probe_y;
  logic [5:0]            r_tank_x;
  logic [5:0]            r_tank_y;
  logic [1:0]            r_tank_dir;
  logic signed [6:0]     w_dx;
  logic signed [6:0]     w_dy;
  logic signed [6:0]     w_tgt_x;
  logic signed [6:0]     w_tgt_y;
  logic                  w_tgt_ok;

  // One-cell step in 7 bits signed, so 0-1 becomes -1 instead of wrapping.
  function automatic logic signed [6:0] step_coord(input logic [5:0] pos,
                                                   input logic signed [6:0] delta);
    return $signed({1'b0, pos}) + delta;
  endfunction

  function automatic logic in_span(input logic signed [6:0] v,
                                   input logic signed [6:0] lo,
                                   input logic signed [6:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Target center for the latched command direction and its bounds check.
  always_comb begin
    w_dx = '0;
    w_dy = '0;
    case (r_cmd_dir)
      2'd0:    w_dy = -7'sd1;
      2'd1:    w_dy = 7'sd1;
      2'd2:    w_dx = -7'sd1;
      default: w_dx = 7'sd1;
    endcase
    w_tgt_x  = step_coord(r_tank_x, w_dx);
    w_tgt_y  = step_coord(r_tank_y, w_dy);
    w_tgt_ok = in_span(w_tgt_x, X_LO, X_HI) && in_span(w_tgt_y, Y_LO, Y_HI);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic. PROBE spends its first cycle on the bounds check;
  // the ack is only looked at once the request is actually out.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.i_cmd_valid)
          w_next = (bus.i_cmd_dir != r_tank_dir) ? S_TURN : S_PROBE;
      end
      S_TURN: begin
`ifdef TANK_MOVE_TURN_IN_PLACE_EN
        w_next = S_COOL;
`else
        w_next = S_PROBE;
`endif
      end
      S_PROBE: begin
        if (!r_probe_valid) begin
          if (!w_tgt_ok) w_next = S_COOL;
        end else if (bus.i_probe_ack) begin
          w_next = bus.i_probe_hit ? S_COOL : S_MOVE;
        end
      end
      S_MOVE:  w_next = S_COOL;
      S_COOL: begin
        if (r_cnt == 8'd0)
          w_next = S_IDLE;
        else if (i_frame_tick && (r_cnt == 8'd1))
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode from the state register only.
  always_comb begin
    bus.o_cmd_ready = (r_state == S_IDLE);
    o_busy          = (r_state != S_IDLE);
  end

  // Tank position/heading, probe request and cooldown counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tank_x      <= 6'(INIT_X);
      r_tank_y      <= 6'(INIT_Y);
      r_tank_dir    <= 2'(INIT_DIR);
      r_probe_valid <= 1'b0;
      r_probe_x     <= '0;
      r_probe_y     <= '0;
      r_cnt         <= '0;
    end else begin
      if (r_state == S_TURN) r_tank_dir <= r_cmd_dir;
      if (r_state == S_MOVE) begin
        r_tank_x <= r_probe_x;
        r_tank_y <= r_probe_y;
      end
      if (r_state == S_PROBE) begin
        if (!r_probe_valid) begin
          if (w_tgt_ok) begin
            r_probe_valid <= 1'b1;
            r_probe_x     <= w_tgt_x[5:0];
            r_probe_y     <= w_tgt_y[5:0];
          end
        end else if (bus.i_probe_ack) begin
          r_probe_valid <= 1'b0;
        end
      end
      if ((w_next == S_COOL) && (r_state != S_COOL))
        r_cnt <= 8'(COOLDOWN_TICKS);
      else if ((r_state == S_COOL) && i_frame_tick && (r_cnt != 8'd0))
        r_cnt <= r_cnt - 8'd1;
    end
  end

  // Command direction is pure data: captured on acceptance, no reset needed.
  always_ff @(posedge i_clk) begin
    if ((r_state == S_IDLE) && bus.i_cmd_valid) r_cmd_dir <= bus.i_cmd_dir;
  end

  assign bus.o_probe_valid = r_probe_valid;
  assign bus.o_probe_x     = r_probe_x;
  assign bus.o_probe_y     = r_probe_y;
  assign o_tank_x          = r_tank_x;
  assign o_tank_y          = r_tank_y;
  assign o_tank_dir        = r_tank_dir;

endmodule

// File: tb/tb_tank_move_ctrl.sv
// Directed bench for tank_move_ctrl: default instance plus an INIT_Y=2
// instance sitting on the top edge of the playfield.
`timescale 1ns/1ps
module tb_tank_move_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;

  tank_move_ctrl_if bus1 ();
  tank_move_ctrl_if bus2 ();

  logic [5:0] x1, y1, x2, y2;
  logic [1:0] d1, d2;
  logic       busy1, busy2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tank_move_ctrl u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_frame_tick (tick),
    .bus          (bus1),
    .o_tank_x     (x1),
    .o_tank_y     (y1),
    .o_tank_dir   (d1),
    .o_busy       (busy1)
  );

  tank_move_ctrl #(.INIT_Y(2)) u_dut_edge (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_frame_tick (tick),
    .bus          (bus2),
    .o_tank_x     (x2),
    .o_tank_y     (y2),
    .o_tank_dir   (d2),
    .o_busy       (busy2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick1();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // Four ticks on the default instance: busy through the 3rd, ready after the 4th.
  task automatic cool1(input string tag);
    for (int i = 0; i < 3; i++) begin
      tick1();
      chk({tag, "_cool_ready"}, bus1.o_cmd_ready, 1'b0);
    end
    tick1();
    chk({tag, "_ready_back"}, bus1.o_cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus1.i_cmd_valid = 0; bus1.i_cmd_dir = 0; bus1.i_probe_ack = 0; bus1.i_probe_hit = 0;
    bus2.i_cmd_valid = 0; bus2.i_cmd_dir = 0; bus2.i_probe_ack = 0; bus2.i_probe_hit = 0;

    // Reset state
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_x", x1, 20);
    chk("rst_y", y1, 15);
    chk("rst_dir", d1, 0);
    chk("rst_ready", bus1.o_cmd_ready, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_pv", bus1.o_probe_valid, 0);
    chk("rst_px", bus1.o_probe_x, 0);
    chk("rst_py", bus1.o_probe_y, 0);

    // Move up with a clear probe
    bus1.i_cmd_valid = 1; bus1.i_cmd_dir = 0;
    step();
    bus1.i_cmd_valid = 0;
    chk("up_ready", bus1.o_cmd_ready, 0);
    chk("up_busy", busy1, 1);
    chk("up_pv_entry", bus1.o_probe_valid, 0);
    step();
    chk("up_pv", bus1.o_probe_valid, 1);
    chk("up_px", bus1.o_probe_x, 20);
    chk("up_py", bus1.o_probe_y, 14);
    bus1.i_probe_ack = 1; bus1.i_probe_hit = 0;
    step();
    bus1.i_probe_ack = 0;
    chk("up_pv_drop", bus1.o_probe_valid, 0);
    chk("up_y_move_cycle", y1, 15);
    step();
    chk("up_y", y1, 14);
    chk("up_x", x1, 20);
    cool1("up");

    // Blocked probe, command held through cooldown
    bus1.i_cmd_valid = 1; bus1.i_cmd_dir = 0;
    step();
    chk("hit_ready", bus1.o_cmd_ready, 0);
    step();
    chk("hit_pv", bus1.o_probe_valid, 1);
    chk("hit_py", bus1.o_probe_y, 13);
    bus1.i_probe_ack = 1; bus1.i_probe_hit = 1;
    step();
    bus1.i_probe_ack = 0; bus1.i_probe_hit = 0;
    chk("hit_pv_drop", bus1.o_probe_valid, 0);
    chk("hit_y_cool", y1, 14);
    cool1("hit");
    chk("hit_y_after", y1, 14);
    step();
    chk("held_accepted", bus1.o_cmd_ready, 0);
    bus1.i_cmd_valid = 0;
    step();
    chk("held_pv", bus1.o_probe_valid, 1);
    chk("held_py", bus1.o_probe_y, 13);

    // Asynchronous reset in the middle of an outstanding probe
    rst_n = 1'b0;
    #1;
    chk("arst_pv", bus1.o_probe_valid, 0);
    chk("arst_ready", bus1.o_cmd_ready, 1);
    chk("arst_x", x1, 20);
    chk("arst_y", y1, 15);
    chk("arst_dir", d1, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_ready_after", bus1.o_cmd_ready, 1);
    chk("arst_pv_after", bus1.o_probe_valid, 0);

    // Direction change to right from (20,15)
    bus1.i_cmd_valid = 1; bus1.i_cmd_dir = 3;
    step();
    bus1.i_cmd_valid = 0;
    chk("turn_ready", bus1.o_cmd_ready, 0);
    chk("turn_dir_early", d1, 0);
    step();
    chk("turn_dir", d1, 3);
    chk("turn_pv", bus1.o_probe_valid, 0);
    chk("turn_x", x1, 20);
`ifdef TANK_MOVE_TURN_IN_PLACE_EN
    cool1("turn");
    chk("turn_x_after", x1, 20);
    chk("turn_pv_after", bus1.o_probe_valid, 0);
`else
    step();
    chk("turn_pv_rise", bus1.o_probe_valid, 1);
    chk("turn_px", bus1.o_probe_x, 21);
    chk("turn_py", bus1.o_probe_y, 15);
    bus1.i_probe_ack = 1; bus1.i_probe_hit = 0;
    step();
    bus1.i_probe_ack = 0;
    step();
    chk("turn_x_moved", x1, 21);
    cool1("turn");
`endif

    // Top-edge instance: stepping up is out of bounds
    bus2.i_cmd_valid = 1; bus2.i_cmd_dir = 0;
    step();
    bus2.i_cmd_valid = 0;
    chk("edge_ready", bus2.o_cmd_ready, 0);
    chk("edge_pv_entry", bus2.o_probe_valid, 0);
    step();
    chk("edge_pv_cool", bus2.o_probe_valid, 0);
    chk("edge_y", y2, 2);
    chk("edge_busy", busy2, 1);
    for (int i = 0; i < 3; i++) begin
      tick1();
      chk("edge_cool_ready", bus2.o_cmd_ready, 0);
    end
    tick1();
    chk("edge_ready_back", bus2.o_cmd_ready, 1);
    chk("edge_y_after", y2, 2);
    chk("edge_pv_after", bus2.o_probe_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tank_move_ctrl.md
# tank_move_ctrl

Sequences one tank's position and heading on the game grid and drives the `tank_x`, `tank_y` and `tank_dir` inputs of the tank sprite display stage. It accepts movement commands from the player input decoder through a valid/ready handshake and checks playfield bounds. It queries the map/collision logic through a request/acknowledge probe before each step. After every command it enforces a cooldown measured in game frame ticks.

## Interface
Parameters:
- `GAME_W`, 40: playfield width in grid cells, valid range 5..63.
- `GAME_H`, 30: playfield height in grid cells, valid range 5..63.
- `INIT_X`, 20: reset x of the tank center.
- `INIT_Y`, 15: reset y of the tank center.
- `INIT_DIR`, 0: reset heading.
- `COOLDOWN_TICKS`, 4: frame ticks to wait after each command, 0..255.

Ports:
- `i_clk`, in, 1: single clock.
- `i_rst_n`, in, 1: asynchronous, active-low reset.
- `i_frame_tick`, in, 1: one-cycle pulse, once per game frame.
- `i_cmd_valid`, in, 1: a movement command is present.
- `i_cmd_dir`, in, 2: requested direction. Encoding: 0 up (y−1), 1 down (y+1), 2 left (x−1), 3 right (x+1).
- `o_cmd_ready`, out, 1: high only in IDLE.
- `o_probe_valid`, out, 1: probe request is active.
- `o_probe_x`, out, 6: target center x for the probe.
- `o_probe_y`, out, 6: target center y for the probe.
- `i_probe_ack`, in, 1: the map has answered the probe.
- `i_probe_hit`, in, 1: the target footprint is blocked; valid only together with `i_probe_ack`.
- `o_tank_x`, out, 6: registered tank center x.
- `o_tank_y`, out, 6: registered tank center y.
- `o_tank_dir`, out, 2: registered tank heading.
- `o_busy`, out, 1: equals `~o_cmd_ready`.

## Operation
- States: IDLE, TURN, PROBE, MOVE, COOL.
- IDLE:
  - When `i_cmd_valid & o_cmd_ready`, latch `i_cmd_dir` as `cmd_dir`.
  - If `cmd_dir != o_tank_dir`, go to TURN; otherwise go to PROBE.
- TURN:
  - Write `o_tank_dir <= cmd_dir`.
  - Next state is COOL, or PROBE, depending on the configuration macro.
- PROBE, entry: compute the target center as the current center plus one cell in `cmd_dir`. Use 7-bit arithmetic so that no wrap occurs.
- Bounds rule: the 5×5 footprint must stay inside the playfield. Valid target x is 2..GAME_W−3; valid y is 2..GAME_H−3.
  - Target out of bounds: no probe is issued, `o_probe_valid` stays 0, and the next state is COOL.
  - Target in bounds: hold `o_probe_valid=1` with a stable `o_probe_x`/`o_probe_y` until `i_probe_ack`.
- Probe answer:
  - `hit=1`: go to COOL with position unchanged.
  - `hit=0`: go to MOVE.
- MOVE: load `o_tank_x`/`o_tank_y` from the probe target, then go to COOL.
- COOL:
  - Load the counter with `COOLDOWN_TICKS` on entry.
  - Decrement on each `i_frame_tick`; go to IDLE when it reaches 0.
  - If `COOLDOWN_TICKS=0`, COOL lasts exactly one cycle.
- `i_frame_tick` is ignored outside COOL. `i_probe_ack` is ignored outside PROBE.
- Commands presented while busy are not consumed. The requester holds `i_cmd_valid`.
- Reset values:
  - State IDLE.
  - `o_tank_x=INIT_X`, `o_tank_y=INIT_Y`, `o_tank_dir=INIT_DIR`.
  - `o_cmd_ready=1`, `o_busy=0`, `o_probe_valid=0`, `o_probe_x=0`, `o_probe_y=0`.
  - Cooldown counter 0.
- Reset asserted mid-operation aborts any probe immediately, asynchronously. No partial position update survives.

## Timing
- All outputs are registered; none is combinationally dependent on any input.
- Command accepted at edge N. TURN or PROBE is active in cycle N+1.
- TURN: `o_tank_dir` is updated and visible from cycle N+2.
- In-bounds probe: `o_probe_valid` rises in cycle N+2. An ack is legal in that same cycle.
- Ack sampled at edge A: MOVE is in cycle A+1, and the new position is visible from A+2.
- The last counted `i_frame_tick`, sampled at edge T, makes `o_cmd_ready=1` from cycle T+1.
- An `i_frame_tick` arriving in the COOL entry cycle is counted.

## Configuration
- `TANK_MOVE_TURN_IN_PLACE_EN` defined: a direction change only rotates the tank (TURN→COOL). A second command in the same direction is needed to move.
- Not defined: TURN→PROBE, so the tank rotates and steps in one command. The cooldown is applied once.

## Test plan
- Reset with defaults → `o_tank_x=20`, `o_tank_y=15`, `o_tank_dir=0`, `o_cmd_ready=1`, `o_probe_valid=0`.
- Command dir 0, then ack with hit=0 two cycles later → probe at (20,14). `o_tank_y=14` at ack+2. Ready returns one cycle after the 4th frame tick.
- Command dir 3 from (20,15):
  - Macro defined → `o_tank_dir=3`, no probe, x stays 20.
  - Macro undefined → probe at (21,15), then `o_tank_x=21`.
- Instance with `INIT_Y=2`, command dir 0 → no probe pulse, y stays 2, COOL entered, ready after 4 ticks.
- Probe answered with hit=1 → position unchanged. A command held valid during COOL is accepted only on the first IDLE cycle.
- `i_rst_n` pulsed low while `o_probe_valid=1` → probe drops immediately. Outputs return to (20,15,0) and ready=1.
